// File: rtl/riscv_mc_control.sv
// riscv_mc_control: multicycle control FSM for the simplified RISC-V core
// Sequences fetch/decode/execute/memory/writeback and drives the datapath
// mux selects, write strobes and ALUControl.
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   opcode/funct3/funct7_5 instruction fields from the instruction register
//   zero                  ALU zero flag (branch decision)
//   mem_ready             unified memory completes the access this cycle
//   PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite  strobes and address select
//   ResultSrc, ALUSrcA, ALUSrcB, ALUControl       datapath selects
//   instr_retired         1-cycle pulse on the final cycle of an instruction
//   err_timeout           sticky memory-wait timeout flag
//   illegal_instr         only with ILLEGAL_TRAP_EN: high while trapped
// Build option ILLEGAL_TRAP_EN: undecoded instructions park in a trap state
// until reset instead of retiring as a NOP.
module riscv_mc_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic       instr_retired,
  output logic       err_timeout
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal_instr
`endif
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_t;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);
`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILL_NEXT = S_TRAP;
`else
  localparam state_t ILL_NEXT = S_FETCH;
`endif
  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic             is_ld, is_st, is_r, is_i, is_b, is_j, f3_ok, illegal, waiting;
  logic [3:0]       alu_fn;
  assign is_ld   = opcode == 7'b0000011;
  assign is_st   = opcode == 7'b0100011;
  assign is_r    = opcode == 7'b0110011;
  assign is_i    = opcode == 7'b0010011;
  assign is_b    = opcode == 7'b1100011;
  assign is_j    = opcode == 7'b1101111;
  assign f3_ok   = funct3 == 3'b000 || funct3 == 3'b110 || funct3 == 3'b111;
  assign illegal = !(is_ld || is_st || ((is_r || is_i) && f3_ok) ||
                     (is_b && funct3 == 3'b000) || is_j);
  // funct7_5 selects SUB only for R-type; for I-type that bit is immediate data
  assign alu_fn  = funct3 == 3'b111 ? ALU_AND :
                   funct3 == 3'b110 ? ALU_OR  :
                   (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
  // counter only runs in memory wait states; any mem_ready clears it
  assign waiting    = (state_q == S_FETCH || state_q == S_MEMREAD || state_q == S_MEMWRITE) && !mem_ready;
  assign wait_cnt_d = !waiting ? '0 : (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + 1'b1;
  // flag registers at the edge ending the MEM_TIMEOUT-th consecutive wait cycle
  assign err_d      = err_q || (MEM_TIMEOUT != 0 && waiting && wait_cnt_d == TIMEOUT);
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   state_d = (is_ld || is_st)           ? S_MEMADR :
                            (is_r && f3_ok)            ? S_EXECR  :
                            (is_i && f3_ok)            ? S_EXECI  :
                            (is_b && funct3 == 3'b000) ? S_BEQ    :
                            is_j                       ? S_JAL    : ILL_NEXT;
      S_MEMADR:   state_d = is_st ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ: state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end
  always_comb begin
    PCWrite       = 1'b0;
    AdrSrc        = 1'b0;
    IRWrite       = 1'b0;
    MemWrite      = 1'b0;
    RegWrite      = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUControl    = ALU_ADD;
    instr_retired = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
`ifndef ILLEGAL_TRAP_EN
        instr_retired = illegal;
`endif
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        RegWrite      = 1'b1;
        instr_retired = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        MemWrite      = 1'b1;
        instr_retired = mem_ready;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_fn;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_fn;
      end
      S_ALUWB: begin
        RegWrite      = 1'b1;
        instr_retired = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA       = 2'b10;
        ALUControl    = ALU_SUB;
        PCWrite       = zero;
        instr_retired = 1'b1;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    // reset kills every strobe in the same cycle so nothing partial is written
    if (reset) begin
      PCWrite       = 1'b0;
      AdrSrc        = 1'b0;
      IRWrite       = 1'b0;
      MemWrite      = 1'b0;
      RegWrite      = 1'b0;
      ResultSrc     = 2'b00;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      ALUControl    = ALU_ADD;
      instr_retired = 1'b0;
    end
  end
  assign err_timeout = err_q && !reset;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = state_q == S_TRAP && !reset;
`endif
endmodule
